core_inst_seq: RTL and testbench

- Hardware instruction sequencer that sits directly upstream of `core`. It produces the 34-bit `inst` word that the bench currently drives by hand.
- For each of `len_kij` kernel positions it steps through a fixed sequence:
  1. xmem weights → L0
  2. L0 → PE weight load
  3. intermission
  4. xmem activations → L0
  5. execute
  6. OFIFO drain with SFU accumulate
- It asserts `done` after the last kij.
- Weights and activations are already resident in xmem; this block never writes xmem.

---
 rtl/core_inst_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// core_inst_seq: generates the 34-bit instruction stream for `core`.
// For each kernel position it fetches weights from xmem into L0, loads them
// into the PE array, waits, fetches activations into L0, executes, and then
// drains the OFIFO through the SFU. `done` pulses once after the last kij.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high
//   start        one-cycle request to begin a full run (ignored while busy)
//   ofifo_valid  OFIFO in `core` holds at least one vector
//   inst[33:0]   registered instruction word to `core`
//   busy         high while a run is in progress
//   done         one-cycle pulse at the end of a run
//   kij[3:0]     current kernel index
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start, emits IDLE_INST
// W_L0       | xmem weight vectors -> L0 (col+1 cycles)
// W_LOAD     | L0 -> PE weight load (col+row cycles) plus one idle cycle
// GAP        | gap idle cycles before activation fetch
// X_L0       | xmem activation vectors -> L0 (len_nij+1 cycles)
// EXEC       | execute (row+col+len_nij cycles) plus one idle cycle
// DRAIN_WAIT | waits for ofifo_valid, then issues one OFIFO read + acc
// DRAIN_SLOT | two idle cycles covering FIFO-valid and SFU latency
// NEXT       | advances kij or finishes
// DONE       | raises done, drops busy

module core_inst_seq #(
   parameter int          row      = 8,
   parameter int          col      = 8,
   parameter int          len_nij  = 36,
   parameter int          len_onij = 16,
   parameter int          len_kij  = 9,
   parameter int          gap      = 10,
   parameter logic [10:0] w_base   = 11'h400,
   parameter logic [10:0] x_base   = 11'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        busy,
   output logic        done,
   output logic [3:0]  kij
);

   localparam int CNT_A   = row + col + len_nij;
   localparam int CNT_B   = (len_nij + 1 > gap) ? len_nij + 1 : gap;
   localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int OW      = $clog2(len_onij + 1);

   localparam logic [33:0]   IDLE_INST = 34'h1_800C_0000;

   // Timer reload values: a phase of N cycles loads N-1 and ends at zero.
   localparam logic [CW-1:0] T_W_L0   = CW'(col);
   localparam logic [CW-1:0] T_W_LOAD = CW'(col + row);
   localparam logic [CW-1:0] T_GAP    = CW'(gap - 1);
   localparam logic [CW-1:0] T_X_L0   = CW'(len_nij);
   localparam logic [CW-1:0] T_EXEC   = CW'(row + col + len_nij);
   localparam logic [CW-1:0] T_SLOT   = CW'(1);
   localparam logic [OW-1:0] N_ONIJ   = OW'(len_onij);
   localparam logic [3:0]    KIJ_LAST = 4'(len_kij - 1);

   localparam int B_ACC    = 33;
   localparam int B_CEN_X  = 19;
   localparam int B_OFR    = 6;
   localparam int B_L0_RD  = 3;
   localparam int B_L0_WR  = 2;
   localparam int B_EXEC   = 1;
   localparam int B_LOAD   = 0;

   typedef enum logic [3:0] {
      IDLE, W_L0, W_LOAD, GAP, X_L0, EXEC, DRAIN_WAIT, DRAIN_SLOT, NEXT, DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  tmr_q, tmr_d;
   logic [OW-1:0]  onij_q, onij_d;
   logic [3:0]     kij_q, kij_d;
   logic [33:0]    inst_q, inst_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [CW-1:0]  off;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      onij_d  = onij_q;
      kij_d   = kij_q;
      inst_d  = IDLE_INST;
      busy_d  = busy_q;
      done_d  = 1'b0;
      off     = '0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = W_L0;
               tmr_d   = T_W_L0;
               onij_d  = '0;
               kij_d   = '0;
               busy_d  = 1'b1;
            end
         end
         W_L0: begin
            // Address leads l0_wr by one cycle; the last cycle holds the
            // final address with the SRAM deselected while L0 takes the data.
            off                 = T_W_L0 - tmr_q;
            inst_d[B_CEN_X]     = (tmr_q == '0);
            inst_d[17:7]        = w_base + ((tmr_q == '0) ? 11'(col - 1) : 11'(off));
            inst_d[B_L0_WR]     = (tmr_q != T_W_L0);
            if (tmr_q == '0) begin
               state_d = W_LOAD;
               tmr_d   = T_W_LOAD;
            end else begin
               tmr_d = tmr_q - CW'(1);
            end
         end
         W_LOAD: begin
            if (tmr_q == '0) begin
               state_d = GAP;
               tmr_d   = T_GAP;
            end else begin
               inst_d[B_LOAD]  = 1'b1;
               inst_d[B_L0_RD] = 1'b1;
               tmr_d           = tmr_q - CW'(1);
            end
         end
         GAP: begin
            if (tmr_q == '0) begin
               state_d = X_L0;
               tmr_d   = T_X_L0;
            end else begin
               tmr_d = tmr_q - CW'(1);
            end
         end
         X_L0: begin
            off             = T_X_L0 - tmr_q;
            inst_d[B_CEN_X] = (tmr_q == '0);
            inst_d[17:7]    = x_base + ((tmr_q == '0) ? 11'(len_nij - 1) : 11'(off));
            inst_d[B_L0_WR] = (tmr_q != T_X_L0);
            if (tmr_q == '0) begin
               state_d = EXEC;
               tmr_d   = T_EXEC;
            end else begin
               tmr_d = tmr_q - CW'(1);
            end
         end
         EXEC: begin
            if (tmr_q == '0) begin
               state_d = DRAIN_WAIT;
            end else begin
               inst_d[B_EXEC]  = 1'b1;
               inst_d[B_L0_RD] = 1'b1;
               tmr_d           = tmr_q - CW'(1);
            end
         end
         DRAIN_WAIT: begin
            // The onij guard keeps reads bounded even if ofifo_valid stays high.
            if (onij_q == N_ONIJ) begin
               state_d = NEXT;
            end else if (ofifo_valid) begin
               inst_d[B_ACC]  = 1'b1;
               inst_d[B_OFR]  = 1'b1;
               inst_d[30:20]  = 11'(onij_q);
               onij_d         = onij_q + OW'(1);
               state_d        = DRAIN_SLOT;
               tmr_d          = T_SLOT;
            end
         end
         DRAIN_SLOT: begin
            if (tmr_q == '0) begin
               state_d = (onij_q == N_ONIJ) ? NEXT : DRAIN_WAIT;
            end else begin
               tmr_d = tmr_q - CW'(1);
            end
         end
         NEXT: begin
            onij_d = '0;
            tmr_d  = '0;
            if (kij_q == KIJ_LAST) begin
               state_d = DONE;
            end else begin
               kij_d   = kij_q + 4'd1;
               state_d = W_L0;
               tmr_d   = T_W_L0;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         onij_q  <= '0;
         kij_q   <= '0;
         inst_q  <= IDLE_INST;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         onij_q  <= onij_d;
         kij_q   <= kij_d;
         inst_q  <= inst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;
   assign kij  = kij_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq with default parameters. A small OFIFO
// model supplies ofifo_valid from a vector count that each read consumes.

module tb_core_inst_seq;

   localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;
   logic [3:0]  kij;

   logic        valid_force = 1'b0;
   logic        valid_en = 1'b0;
   int          fifo_cnt = 0;
   int          n_total = 0;
   int          n_bad = 0;

   assign ofifo_valid = valid_force | (valid_en && (fifo_cnt > 0));

   core_inst_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .kij         (kij)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] act, input logic [33:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [33:0] fill_inst(input logic [10:0] a, input bit cen, input bit wr);
      logic [33:0] w;
      w        = IDLE_INST;
      w[19]    = cen;
      w[17:7]  = a;
      w[2]     = wr;
      return w;
   endfunction

   function automatic logic [33:0] rd_inst(input int n);
      logic [33:0] w;
      w        = IDLE_INST;
      w[33]    = 1'b1;
      w[6]     = 1'b1;
      w[30:20] = 11'(n);
      return w;
   endfunction

   // One full run with an always-valid OFIFO; returns cycles from start to done.
   task automatic run_full(input bit extra_start, output int cyc);
      int         done_cnt;
      logic [3:0] prev;
      valid_force = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("run_busy", 34'(busy), 34'd1);
      chk("run_kij0", 34'(kij), 34'd0);
      prev = 4'd0;
      cyc  = 0;
      while (done !== 1'b1 && cyc < 4000) begin
         if (extra_start && cyc == 100) start = 1'b1;
         step();
         cyc++;
         start = 1'b0;
         if (kij !== prev) begin
            chk("kij_step", 34'(kij), 34'(prev + 4'd1));
            prev = kij;
         end
      end
      chk("run_done_cyc", 34'(cyc), 34'd1576);
      chk("run_done_busy", 34'(busy), 34'd0);
      chk("run_done_kij", 34'(kij), 34'd8);
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done === 1'b1) done_cnt++;
      end
      chk("run_done_once", 34'(done_cnt), 34'd0);
      chk("run_idle_inst", inst, IDLE_INST);
      valid_force = 1'b0;
   endtask

   initial begin
      int reads;
      int cyc;
      int last;
      int n1;
      int n2;
      int done_cnt;

      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_inst", inst, IDLE_INST);
      chk("rst_busy", 34'(busy), 34'd0);
      chk("rst_done", 34'(done), 34'd0);
      chk("rst_kij", 34'(kij), 34'd0);
      step();
      chk("idle_hold", inst, IDLE_INST);

      // Detailed walk through kij=0.
      fifo_cnt = 16;
      valid_en = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", 34'(busy), 34'd1);
      for (int t = 0; t <= 8; t++) begin
         step();
         chk("w_l0", inst, fill_inst(11'h400 + 11'((t < 8) ? t : 7), (t == 8), (t >= 1)));
      end
      for (int t = 0; t < 16; t++) begin
         step();
         chk("w_load", inst, IDLE_INST | 34'h9);
      end
      for (int t = 0; t < 11; t++) begin
         step();
         chk("w_gap", inst, IDLE_INST);
      end
      for (int t = 0; t <= 36; t++) begin
         step();
         chk("x_l0", inst, fill_inst(11'((t < 36) ? t : 35), (t == 36), (t >= 1)));
      end
      for (int t = 0; t < 52; t++) begin
         step();
         chk("exec", inst, IDLE_INST | 34'hA);
      end
      step();
      chk("exec_tail", inst, IDLE_INST);

      reads = 0;
      cyc   = 0;
      last  = 0;
      while (kij == 4'd0 && cyc < 400) begin
         step();
         cyc++;
         if (inst[6]) begin
            chk("drain_word", inst, rd_inst(reads));
            if (reads > 0) chk("drain_space", 34'(cyc - last), (reads == 8) ? 34'd23 : 34'd3);
            last = cyc;
            reads++;
            fifo_cnt--;
            if (reads == 8) begin
               valid_en = 1'b0;
               for (int i = 0; i < 22; i++) begin
                  step();
                  cyc++;
                  chk("pause_idle", inst, IDLE_INST);
                  chk("pause_kij", 34'(kij), 34'd0);
               end
               valid_en = 1'b1;
            end
         end else begin
            chk("drain_idle", inst, IDLE_INST);
         end
      end
      chk("drain_reads", 34'(reads), 34'd16);
      chk("drain_next_kij", 34'(kij), 34'd1);
      step();
      chk("kij1_w0", inst, fill_inst(11'h400, 1'b0, 1'b0));

      // Two full runs; the first also gets a stray start while busy.
      valid_en = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_full(1'b1, n1);
      run_full(1'b0, n2);
      chk("run_repeat", 34'(n1), 34'(n2));

      // Abort during EXEC of kij=4, then replay.
      valid_force = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (!(kij == 4'd4 && inst[1] == 1'b1) && cyc < 2000) begin
         step();
         cyc++;
      end
      chk("exec_k4_reached", 34'(kij == 4'd4 && inst[1] == 1'b1), 34'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_inst", inst, IDLE_INST);
      chk("abort_busy", 34'(busy), 34'd0);
      chk("abort_done", 34'(done), 34'd0);
      chk("abort_kij", 34'(kij), 34'd0);
      done_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      chk("abort_no_done", 34'(done_cnt), 34'd0);
      chk("abort_idle", inst, IDLE_INST);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("replay_busy", 34'(busy), 34'd1);
      chk("replay_kij", 34'(kij), 34'd0);
      step();
      chk("replay_w0", inst, fill_inst(11'h400, 1'b0, 1'b0));
      valid_force = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
